// File: rtl/exc_pkg.sv
// exc_pkg: shared exception codes, FSM states and bad-address select for exc_ctrl
package exc_pkg;
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_ERET = 5'h0e;
   localparam logic [4:0] EXC_NONE = 5'h1f;
   typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;
   typedef enum logic [1:0] {BA_HOLD, BA_PC, BA_DATA} ba_sel_t;
endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// exc_prio_enc: combinational priority encoder for exception causes
// Ports: int_pend + eight exception flags in; hit, code, ba_sel, is_eret out.
module exc_prio_enc
   import exc_pkg::*;
(
   input  logic       int_pend,
   input  logic       adel_if,
   input  logic       ri,
   input  logic       ov,
   input  logic       sys,
   input  logic       bp,
   input  logic       adel_m,
   input  logic       ades_m,
   input  logic       eret,
   output logic       hit,
   output logic [4:0] code,
   output ba_sel_t    ba_sel,
   output logic       is_eret
);
   always_comb begin
      hit     = int_pend | adel_if | ri | ov | sys | bp | adel_m | ades_m | eret;
      code    = int_pend ? EXC_INT  :
                adel_if  ? EXC_ADEL :
                ri       ? EXC_RI   :
                ov       ? EXC_OV   :
                sys      ? EXC_SYS  :
                bp       ? EXC_BP   :
                adel_m   ? EXC_ADEL :
                ades_m   ? EXC_ADES :
                eret     ? EXC_ERET : EXC_NONE;
      // only address errors update the bad address, and only when they win
      ba_sel  = (int_pend | (!adel_if & (ri | ov | sys | bp))) ? BA_HOLD :
                adel_if            ? BA_PC   :
                (adel_m | ades_m)  ? BA_DATA : BA_HOLD;
      is_eret = code == EXC_ERET;
   end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception collection, one-cycle commit to CP0, flush and redirect
// Ports: clk, rst (sync active-low); MEM instruction info and exception flags; CP0
// status_i/cause_i/epc_i; registered record exc_code_o/badaddr_o/delayslot_o/pc_o;
// flush_o, redirect_o, redirect_pc_o.
// Optional: define EXC_STAT_EN to add exc_count_o (committed non-ERET exceptions).
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_m,
   input  logic        stall_i,
   input  logic [31:0] pc_m,
   input  logic        delayslot_m,
   input  logic [31:0] data_addr_m,
   input  logic        adel_if_m,
   input  logic        ri_m,
   input  logic        ov_m,
   input  logic        sys_m,
   input  logic        bp_m,
   input  logic        adel_m,
   input  logic        ades_m,
   input  logic        eret_m,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [4:0]  exc_code_o,
   output logic [31:0] badaddr_o,
   output logic        delayslot_o,
   output logic [31:0] pc_o,
   output logic        flush_o,
   output logic        redirect_o,
`ifdef EXC_STAT_EN
   output logic [31:0] exc_count_o,
`endif
   output logic [31:0] redirect_pc_o
);
   // FLUSH holds FLUSH_CYCLES-1 cycles; the counter ends on this value
   localparam logic [3:0] LAST = 4'(FLUSH_CYCLES - 2);
   state_t     state;
   logic [3:0] cnt;
   logic       int_pend, hit, is_eret, capture;
   logic [4:0] code;
   ba_sel_t    ba_sel;
   logic       unused_bits;
   assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
   // EXL (Status[1]) masks interrupts
   assign int_pend = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]);
   assign capture  = valid_m & ~stall_i & (state == IDLE) & hit;
   exc_prio_enc u_enc (
      .int_pend (int_pend),
      .adel_if  (adel_if_m),
      .ri       (ri_m),
      .ov       (ov_m),
      .sys      (sys_m),
      .bp       (bp_m),
      .adel_m   (adel_m),
      .ades_m   (ades_m),
      .eret     (eret_m),
      .hit      (hit),
      .code     (code),
      .ba_sel   (ba_sel),
      .is_eret  (is_eret)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         exc_code_o    <= EXC_NONE;
         flush_o       <= 1'b0;
         redirect_o    <= 1'b0;
         badaddr_o     <= '0;
         pc_o          <= '0;
         delayslot_o   <= 1'b0;
         redirect_pc_o <= '0;
`ifdef EXC_STAT_EN
         exc_count_o   <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (capture) begin
               state         <= COMMIT;
               exc_code_o    <= code;
               flush_o       <= 1'b1;
               redirect_o    <= 1'b1;
               pc_o          <= pc_m;
               delayslot_o   <= delayslot_m;
               badaddr_o     <= ba_sel == BA_PC ? pc_m : ba_sel == BA_DATA ? data_addr_m : badaddr_o;
               redirect_pc_o <= is_eret ? epc_i : EXC_VECTOR;
            end
            COMMIT: begin
               exc_code_o <= EXC_NONE;
               redirect_o <= 1'b0;
`ifdef EXC_STAT_EN
               if (exc_code_o != EXC_ERET) exc_count_o <= exc_count_o + 32'd1;
`endif
               if (FLUSH_CYCLES == 1) begin
                  state   <= IDLE;
                  flush_o <= 1'b0;
               end else begin
                  state <= FLUSH;
                  cnt   <= '0;
               end
            end
            FLUSH: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST) begin
                  state   <= IDLE;
                  flush_o <= 1'b0;
                  cnt     <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table vectors, corner sequences and randomized checking against a cycle model
module tb_exc_ctrl;
   localparam int          FC  = 2;
   localparam logic [31:0] VEC = 32'hBFC00380;
   localparam logic [4:0]  NONE = 5'h1f;
   localparam logic [4:0]  CODES [9] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, 5'h0e};
   logic        clk = 0, rst, valid_m, stall_i, delayslot_m;
   logic [31:0] pc_m, data_addr_m, status_i, cause_i, epc_i;
   logic [7:0]  fl;
   logic        adel_if_m, ri_m, ov_m, sys_m, bp_m, adel_m, ades_m, eret_m;
   logic [4:0]  exc_code_o;
   logic [31:0] badaddr_o, pc_o, redirect_pc_o;
   logic        delayslot_o, flush_o, redirect_o;
`ifdef EXC_STAT_EN
   logic [31:0] exc_count_o;
`endif
   int npass = 0, ntot = 0;
   assign {adel_if_m, ri_m, ov_m, sys_m, bp_m, adel_m, ades_m, eret_m} = fl;
   always #5 clk = ~clk;
   exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .valid_m(valid_m), .stall_i(stall_i), .pc_m(pc_m),
      .delayslot_m(delayslot_m), .data_addr_m(data_addr_m),
      .adel_if_m(adel_if_m), .ri_m(ri_m), .ov_m(ov_m), .sys_m(sys_m), .bp_m(bp_m),
      .adel_m(adel_m), .ades_m(ades_m), .eret_m(eret_m),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .exc_code_o(exc_code_o), .badaddr_o(badaddr_o), .delayslot_o(delayslot_o),
      .pc_o(pc_o), .flush_o(flush_o), .redirect_o(redirect_o),
`ifdef EXC_STAT_EN
      .exc_count_o(exc_count_o),
`endif
      .redirect_pc_o(redirect_pc_o)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   // model: rem counts flush cycles still owed; the commit cycle is the one with rem==FC
   int          rem = 0;
   logic [4:0]  m_cc = NONE;
   logic [31:0] m_ba = 0, m_pc = 0, m_rpc = 0, m_cnt = 0;
   logic        m_ds = 0;
   always @(posedge clk) begin
      logic [8:0] hits;
      int k;
      if (!rst) begin
         rem = 0; m_ba = 0; m_pc = 0; m_ds = 0; m_rpc = 0; m_cnt = 0;
      end else if (rem > 0) begin
         if (rem == FC && m_cc != 5'h0e) m_cnt++;
         rem--;
      end else if (valid_m && !stall_i) begin
         hits = {status_i[0] && !status_i[1] && ((status_i[15:8] & cause_i[15:8]) != 0), fl};
         k = -1;
         for (int i = 0; i < 9; i++) if (k < 0 && hits[8-i]) k = i;
         if (k >= 0) begin
            m_cc = CODES[k]; rem = FC; m_pc = pc_m; m_ds = delayslot_m;
            if (k == 1) m_ba = pc_m;
            else if (k == 6 || k == 7) m_ba = data_addr_m;
            m_rpc = k == 8 ? epc_i : VEC;
         end
      end
      #1;
      chk("model code", 32'(exc_code_o), 32'(rem == FC ? m_cc : NONE));
      chk("model flush", 32'(flush_o), 32'(rem > 0));
      chk("model redirect", 32'(redirect_o), 32'(rem == FC));
      chk("model pc", pc_o, m_pc);
      chk("model ds", 32'(delayslot_o), 32'(m_ds));
      chk("model badaddr", badaddr_o, m_ba);
      chk("model rpc", redirect_pc_o, m_rpc);
`ifdef EXC_STAT_EN
      chk("model count", exc_count_o, m_cnt);
`endif
   end
   typedef struct {
      logic [31:0] pc, addr, status, cause, epc;
      logic        ds;
      logic [7:0]  fl;
      logic [4:0]  code;
      logic [31:0] ba, rpc;
      logic        chk_ba;
   } vec_t;
   vec_t tv [8];
   initial begin
      rst = 0; valid_m = 0; stall_i = 0; fl = 0; status_i = 0; cause_i = 0; epc_i = 0;
      pc_m = 0; delayslot_m = 0; data_addr_m = 0;
      //           pc            addr          status        cause         epc           ds  fl        code   ba            rpc           chk_ba
      tv[0] = '{32'h80001000, 32'h0,        32'h0,        32'h0,        32'h0,        1, 8'h30, 5'h0c, 32'h0,        VEC,          0};
      tv[1] = '{32'h80001100, 32'h80002003, 32'h0,        32'h0,        32'h0,        0, 8'h02, 5'h05, 32'h80002003, VEC,          1};
      tv[2] = '{32'h80000402, 32'h0,        32'h0,        32'h0,        32'h0,        0, 8'h80, 5'h04, 32'h80000402, VEC,          1};
      tv[3] = '{32'h80001200, 32'h0,        32'h00000401, 32'h00000400, 32'h0,        0, 8'h40, 5'h00, 32'h80000402, VEC,          1};
      tv[4] = '{32'h80001300, 32'h0,        32'h00000403, 32'h00000400, 32'h0,        0, 8'h40, 5'h0a, 32'h80000402, VEC,          1};
      tv[5] = '{32'h80001400, 32'h0,        32'h0,        32'h0,        32'h80003000, 1, 8'h01, 5'h0e, 32'h80000402, 32'h80003000, 1};
      tv[6] = '{32'h80001500, 32'h0,        32'h00000401, 32'h0,        32'h0,        0, 8'h08, 5'h09, 32'h80000402, VEC,          1};
      tv[7] = '{32'h80001600, 32'h80004001, 32'h0,        32'h0,        32'h0,        0, 8'h06, 5'h04, 32'h80004001, VEC,          1};
      repeat (3) @(negedge clk);
      chk("reset code", 32'(exc_code_o), 32'(NONE));
      chk("reset pc", pc_o, 0);
      chk("reset rpc", redirect_pc_o, 0);
      rst = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         valid_m = 1; pc_m = tv[i].pc; data_addr_m = tv[i].addr; status_i = tv[i].status;
         cause_i = tv[i].cause; epc_i = tv[i].epc; delayslot_m = tv[i].ds; fl = tv[i].fl;
         @(posedge clk); #2;
         chk($sformatf("vec%0d code", i), 32'(exc_code_o), 32'(tv[i].code));
         chk($sformatf("vec%0d flush", i), 32'(flush_o), 1);
         chk($sformatf("vec%0d redirect", i), 32'(redirect_o), 1);
         chk($sformatf("vec%0d pc", i), pc_o, tv[i].pc);
         chk($sformatf("vec%0d ds", i), 32'(delayslot_o), 32'(tv[i].ds));
         chk($sformatf("vec%0d rpc", i), redirect_pc_o, tv[i].rpc);
         if (tv[i].chk_ba) chk($sformatf("vec%0d badaddr", i), badaddr_o, tv[i].ba);
         @(negedge clk);
         valid_m = 0; fl = 0; status_i = 0; cause_i = 0;
         @(posedge clk); #2;
         chk($sformatf("vec%0d flush2", i), 32'(flush_o), 1);
         chk($sformatf("vec%0d code2", i), 32'(exc_code_o), 32'(NONE));
         repeat (FC + 1) @(negedge clk);
      end
      // reset held for 3 cycles from the middle of FLUSH
      @(negedge clk); valid_m = 1; fl = 8'h20;
      @(negedge clk); valid_m = 0; fl = 0;
      @(negedge clk); rst = 0;
      @(posedge clk); #2;
      chk("rst flush", 32'(flush_o), 0);
      chk("rst code", 32'(exc_code_o), 32'(NONE));
      chk("rst redirect", 32'(redirect_o), 0);
      repeat (3) @(negedge clk);
      rst = 1;
      // stall blocks capture; capture follows release; new flags during FLUSH are ignored
      @(negedge clk); valid_m = 1; fl = 8'h20; stall_i = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         chk("stall flush", 32'(flush_o), 0);
      end
      @(negedge clk); stall_i = 0;
      @(posedge clk); #2;
      chk("unstall code", 32'(exc_code_o), 32'h0c);
      chk("unstall flush", 32'(flush_o), 1);
      @(negedge clk); valid_m = 0; fl = 0;
      @(posedge clk); #2;
      chk("flush state", 32'(flush_o), 1);
      @(negedge clk); valid_m = 1; fl = 8'h10; stall_i = 1;
      @(posedge clk); #2;
      chk("ignored code", 32'(exc_code_o), 32'(NONE));
      chk("ignored flush", 32'(flush_o), 0);
      @(negedge clk); valid_m = 0; fl = 0; stall_i = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom % 150) != 0;
         valid_m = ($urandom % 4) != 0;
         stall_i = ($urandom % 5) == 0;
         pc_m = $urandom; data_addr_m = $urandom; epc_i = $urandom;
         delayslot_m = 1'($urandom);
         status_i = ($urandom % 3 == 0) ? $urandom : 32'h0;
         cause_i = $urandom;
         for (int b = 0; b < 8; b++) fl[b] = ($urandom % 12) == 0;
      end
      @(negedge clk); valid_m = 0; fl = 0; rst = 1;
      repeat (FC + 2) @(negedge clk);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception collection and commit stage between the MEM pipeline stage and CP0.
- Gathers per-instruction exception flags and the CP0 interrupt state.
- Picks the single highest-priority cause and presents a registered exception record (code, bad address, delay-slot bit, PC) to CP0 for exactly one cycle.
- Drives the pipeline flush and the fetch redirect to the exception vector or to EPC for ERET.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all non-ERET exceptions
FLUSH_CYCLES, 2, total cycles flush_o stays high per commit (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
valid_m  in  1  MEM stage holds a live instruction
stall_i  in  1  pipeline stall; no capture while high
pc_m  in  32  PC of MEM instruction
delayslot_m  in  1  MEM instruction is in a branch delay slot
data_addr_m  in  32  load/store effective address
adel_if_m, ri_m, ov_m, sys_m, bp_m, adel_m, ades_m, eret_m  in  1 each  exception flags
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause
epc_i  in  32  CP0 EPC
exc_code_o  out  5  code to CP0; EXC_NONE when idle
badaddr_o  out  32  bad virtual address to CP0
delayslot_o  out  1  delay-slot bit to CP0
pc_o  out  32  faulting PC to CP0
flush_o  out  1  flush IF..MEM
redirect_o  out  1  one-cycle fetch redirect strobe
redirect_pc_o  out  32  redirect target

Behaviour:
- Interrupt pending when Status[0]=1, Status[1]=0, and (Status[15:8] & Cause[15:8]) != 0.
- Priority, highest first: INT, adel_if (AdEL), ri, ov, sys, bp, adel_m (AdEL), ades_m, eret.
- Capture occurs when valid_m=1, stall_i=0, state=IDLE, and any cause or the interrupt is present.
- FSM states:
  - IDLE: on capture, register the record and go to COMMIT.
  - COMMIT: lasts exactly 1 cycle. exc_code_o holds the code, flush_o=1, redirect_o=1. If FLUSH_CYCLES=1 go to IDLE, else go to FLUSH.
  - FLUSH: flush_o=1, exc_code_o=EXC_NONE, redirect_o=0. A 4-bit counter runs until FLUSH_CYCLES-1 extra cycles have elapsed, then the FSM goes to IDLE. All inputs are ignored, including stall_i.
- Record contents:
  - pc_o = pc_m; delayslot_o = delayslot_m.
  - badaddr_o = pc_m for adel_if, data_addr_m for adel_m/ades_m, otherwise holds its previous value.
- redirect_pc_o = epc_i sampled in the capture cycle for ERET, otherwise EXC_VECTOR.
- An interrupt is taken only when attached to a valid instruction. With EXL=1 it is masked even if IE and mask bits are set.
- ERET is processed regardless of the EXL value.
- Latency: flags at cycle N produce exc_code_o/flush_o/redirect_o at cycle N+1.
- Reset (rst=0 at a clock edge), including mid-COMMIT/FLUSH:
  - state=IDLE, counter=0.
  - exc_code_o=EXC_NONE; flush_o=0, redirect_o=0.
  - badaddr_o, pc_o, redirect_pc_o = 0; delayslot_o=0.

Optional Feature:
EXC_STAT_EN
- Defined: adds output exc_count_o [31:0]. It increments once per COMMIT cycle, excluding ERET, wraps at 2^32, and resets to 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package exc_pkg holds:
  - Codes EXC_INT=5'h00, EXC_ADEL=5'h04, EXC_ADES=5'h05, EXC_SYS=5'h08, EXC_BP=5'h09, EXC_RI=5'h0a, EXC_OV=5'h0c, EXC_ERET=5'h0e, EXC_NONE=5'h1f.
  - The state enum IDLE/COMMIT/FLUSH.
- One sub-module, exc_prio_enc: combinational priority encoder producing code, bad-address select, and is_eret.

Test Plan:
- Reset held 3 cycles mid-FLUSH -> next cycle flush_o=0, exc_code_o=5'h1f, state IDLE.
- valid_m=1, ov_m=1, sys_m=1, pc_m=32'h80001000, delayslot_m=1 -> next cycle exc_code_o=5'h0c, pc_o=32'h80001000, delayslot_o=1, redirect_pc_o=32'hBFC00380; flush_o high 2 cycles total.
- ades_m=1, data_addr_m=32'h80002003 -> exc_code_o=5'h05, badaddr_o=32'h80002003. Then adel_if_m=1, pc_m=32'h80000402 -> exc_code_o=5'h04, badaddr_o=32'h80000402.
- Status=32'h00000401, Cause[10]=1, valid_m=1, ri_m=1 -> exc_code_o=5'h00. Repeat with Status=32'h00000403 -> exc_code_o=5'h0a.
- eret_m=1, epc_i=32'h80003000 -> exc_code_o=5'h0e, redirect_o=1, redirect_pc_o=32'h80003000. With EXC_STAT_EN defined, exc_count_o unchanged.
- stall_i=1 with ov_m=1 for 4 cycles -> no commit. Release the stall -> commit next cycle. A new sys_m during FLUSH -> ignored.
